md_unit: RTL and testbench

MD_UNIT -- requirements
Module: md_unit

---
 rtl/md_unit.sv | 216 +++++++++++++++++++++
 tb/tb_md_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO result registers.
// Optional accumulate ops (MADD/MADDU/MSUB/MSUBU) are enabled by defining MD_UNIT_MADD_EN.
module md_unit #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       md_op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0]    C_MULT   = CW'(MULT_CYCLES);
  localparam logic [CW-1:0]    C_DIV    = CW'(DIV_CYCLES);
  localparam logic [CW-1:0]    C_ONE    = CW'(1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MADD  = 4'd7,
    OP_MADDU = 4'd8,
    OP_MSUB  = 4'd9,
    OP_MSUBU = 4'd10
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MUL_RUN = 2'd1,
    S_DIV_RUN = 2'd2
  } state_e;

  state_e           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_signed;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic w_is_mul;
  logic w_is_div;
  logic w_sgn;
  logic w_mthi;
  logic w_mtlo;

`ifdef MD_UNIT_MADD_EN
  typedef enum logic [1:0] {
    K_MUL  = 2'd0,
    K_MADD = 2'd1,
    K_MSUB = 2'd2
  } mkind_e;

  mkind_e r_kind;
  mkind_e w_kind;
`endif

  always_comb begin
    w_is_mul = 1'b0;
    w_is_div = 1'b0;
    w_sgn    = 1'b0;
    w_mthi   = 1'b0;
    w_mtlo   = 1'b0;
`ifdef MD_UNIT_MADD_EN
    w_kind   = K_MUL;
`endif
    case (md_op)
      OP_MULT:  begin w_is_mul = 1'b1; w_sgn = 1'b1; end
      OP_MULTU: w_is_mul = 1'b1;
      OP_DIV:   begin w_is_div = 1'b1; w_sgn = 1'b1; end
      OP_DIVU:  w_is_div = 1'b1;
      OP_MTHI:  w_mthi = 1'b1;
      OP_MTLO:  w_mtlo = 1'b1;
`ifdef MD_UNIT_MADD_EN
      OP_MADD:  begin w_is_mul = 1'b1; w_sgn = 1'b1; w_kind = K_MADD; end
      OP_MADDU: begin w_is_mul = 1'b1; w_kind = K_MADD; end
      OP_MSUB:  begin w_is_mul = 1'b1; w_sgn = 1'b1; w_kind = K_MSUB; end
      OP_MSUBU: begin w_is_mul = 1'b1; w_kind = K_MSUB; end
`endif
      default: ;
    endcase
  end

  // One 2W x 2W multiplier serves both signednesses: operands are extended
  // first, and the low 2W bits of the product are exact in either case.
  logic [2*WIDTH-1:0] w_ax;
  logic [2*WIDTH-1:0] w_bx;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_mres;

  assign w_ax   = r_signed ? {{WIDTH{r_a[WIDTH-1]}}, r_a} : {{WIDTH{1'b0}}, r_a};
  assign w_bx   = r_signed ? {{WIDTH{r_b[WIDTH-1]}}, r_b} : {{WIDTH{1'b0}}, r_b};
  assign w_prod = w_ax * w_bx;

`ifdef MD_UNIT_MADD_EN
  always_comb begin
    w_mres = w_prod;
    case (r_kind)
      K_MADD:  w_mres = {r_hi, r_lo} + w_prod;
      K_MSUB:  w_mres = {r_hi, r_lo} - w_prod;
      default: w_mres = w_prod;
    endcase
  end
`else
  assign w_mres = w_prod;
`endif

  logic             w_div_zero;
  logic             w_div_ovf;
  logic [WIDTH-1:0] w_bd;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_r;

  assign w_div_zero = (r_b == '0);
  assign w_div_ovf  = r_signed && (r_a == MOST_NEG) && (r_b == '1);
  // Zero and overflow divisors are replaced so the divider never sees an
  // undefined case; both results are overridden or discarded below.
  assign w_bd       = (w_div_zero || w_div_ovf) ? WIDTH'(1) : r_b;

  always_comb begin
    w_q = r_a / w_bd;
    w_r = r_a % w_bd;
    if (r_signed) begin
      w_q = $unsigned($signed(r_a) / $signed(w_bd));
      w_r = $unsigned($signed(r_a) % $signed(w_bd));
    end
    if (w_div_ovf) begin
      w_q = MOST_NEG;
      w_r = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_signed <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
`ifdef MD_UNIT_MADD_EN
      r_kind   <= K_MUL;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_is_mul || w_is_div) begin
              r_a      <= src_a;
              r_b      <= src_b;
              r_signed <= w_sgn;
              r_busy   <= 1'b1;
              r_state  <= w_is_mul ? S_MUL_RUN : S_DIV_RUN;
              r_cnt    <= w_is_mul ? C_MULT : C_DIV;
`ifdef MD_UNIT_MADD_EN
              r_kind   <= w_kind;
`endif
            end else if (w_mthi) begin
              r_hi <= src_a;
            end else if (w_mtlo) begin
              r_lo <= src_a;
            end
          end
        end
        S_MUL_RUN, S_DIV_RUN: begin
          // Commit on the edge that sees the last remaining count.
          if (r_cnt <= C_ONE) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            if (r_state == S_MUL_RUN) begin
              {r_hi, r_lo} <= w_mres;
            end else if (!w_div_zero) begin
              r_lo <= w_q;
              r_hi <= w_r;
            end
          end else begin
            r_cnt <= r_cnt - C_ONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit (WIDTH=32, MULT_CYCLES=5, DIV_CYCLES=10).
module tb_md_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp;
  int n_err;

  md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .md_op (md_op),
    .src_a (src_a),
    .src_b (src_b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one start for a single edge, then scramble operands.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; md_op = op; src_a = a; src_b = b;
    tick();
    start = 1'b0; md_op = 4'd0; src_a = $urandom; src_b = $urandom;
  endtask

  // Edges until done is seen; -1 if the budget expires.
  task automatic wait_done(output int n);
    bit seen;
    seen = 1'b0;
    n = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      n++;
      if (done === 1'b1) seen = 1'b1;
    end
    if (!seen) n = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; md_op = 4'd0; src_a = '0; src_b = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b want 0", done); end
    n_cmp++; if (hi !== 32'h0) begin n_err++; $display("FAIL rst_hi: got %h want 0", hi); end
    n_cmp++; if (lo !== 32'h0) begin n_err++; $display("FAIL rst_lo: got %h want 0", lo); end
    rst_n = 1'b1;
  endtask

  task automatic test_mult();
    int n;
    int nb;
    issue(4'd1, 32'hFFFFFFFF, 32'd2);
    nb = 0;
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      nb++;
      if (done === 1'b1) begin n_err++; $display("FAIL mult_early_done at busy cycle %0d", nb); end
      tick();
      n++;
    end
    n_cmp++; if (nb != 5) begin n_err++; $display("FAIL mult_busy_cycles: got %0d want 5", nb); end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL mult_done: got %b want 1", done); end
    n_cmp++; if (hi !== 32'hFFFFFFFF) begin n_err++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
    n_cmp++; if (lo !== 32'hFFFFFFFE) begin n_err++; $display("FAIL mult_lo: got %h want fffffffe", lo); end
    tick();
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL mult_done_width: got %b want 0", done); end

    issue(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(n);
    n_cmp++; if (n != 5) begin n_err++; $display("FAIL multu_cycles: got %0d want 5", n); end
    n_cmp++; if ({hi, lo} !== 64'hFFFFFFFE_00000001) begin n_err++; $display("FAIL multu_res: got %h%h want fffffffe00000001", hi, lo); end

    issue(4'd1, 32'hFFFFFFFD, 32'd5);
    wait_done(n);
    n_cmp++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFF1) begin n_err++; $display("FAIL mult_neg: got %h%h want fffffffffffffff1", hi, lo); end
  endtask

  task automatic test_div();
    int n;
    issue(4'd3, 32'hFFFFFFF9, 32'd2);
    wait_done(n);
    n_cmp++; if (n != 10) begin n_err++; $display("FAIL div_cycles: got %0d want 10", n); end
    n_cmp++; if (lo !== 32'hFFFFFFFD) begin n_err++; $display("FAIL div_lo: got %h want fffffffd", lo); end
    n_cmp++; if (hi !== 32'hFFFFFFFF) begin n_err++; $display("FAIL div_hi: got %h want ffffffff", hi); end

    issue(4'd4, 32'd7, 32'd0);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL divz_busy: got %b want 1", busy); end
    wait_done(n);
    n_cmp++; if (n != 10) begin n_err++; $display("FAIL divz_cycles: got %0d want 10", n); end
    n_cmp++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFD) begin n_err++; $display("FAIL divz_keep: got %h%h want fffffffffffffffd", hi, lo); end

    issue(4'd3, 32'h80000000, 32'hFFFFFFFF);
    wait_done(n);
    n_cmp++; if (lo !== 32'h80000000) begin n_err++; $display("FAIL divovf_lo: got %h want 80000000", lo); end
    n_cmp++; if (hi !== 32'h0) begin n_err++; $display("FAIL divovf_hi: got %h want 0", hi); end

    issue(4'd4, 32'd100, 32'd7);
    wait_done(n);
    n_cmp++; if ({hi, lo} !== {32'd2, 32'd14}) begin n_err++; $display("FAIL divu_res: got %h/%h want 2/e", hi, lo); end

    issue(4'd4, 32'hFFFFFFFF, 32'd16);
    wait_done(n);
    n_cmp++; if ({hi, lo} !== {32'hF, 32'h0FFFFFFF}) begin n_err++; $display("FAIL divu_big: got %h/%h want f/0fffffff", hi, lo); end
  endtask

  task automatic test_busy_ignore();
    int n;
    issue(4'd1, 32'd6, 32'd7);
    tick();
    start = 1'b1; md_op = 4'd6; src_a = 32'hDEAD;
    tick();
    start = 1'b1; md_op = 4'd3; src_a = 32'd1; src_b = 32'd1;
    tick();
    start = 1'b0; md_op = 4'd0;
    wait_done(n);
    n_cmp++; if (n != 2) begin n_err++; $display("FAIL ign_cycles: got %0d want 2", n); end
    n_cmp++; if ({hi, lo} !== {32'd0, 32'd42}) begin n_err++; $display("FAIL ign_res: got %h/%h want 0/2a", hi, lo); end

    start = 1'b1; md_op = 4'd5; src_a = 32'h1234;
    tick();
    start = 1'b0;
    n_cmp++; if (hi !== 32'h1234) begin n_err++; $display("FAIL mthi: got %h want 1234", hi); end
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL mthi_flags: got %b%b want 00", busy, done); end
    start = 1'b1; md_op = 4'd6; src_a = 32'h55;
    tick();
    start = 1'b0;
    n_cmp++; if (lo !== 32'h55) begin n_err++; $display("FAIL mtlo: got %h want 55", lo); end
  endtask

  task automatic test_none();
    start = 1'b1; md_op = 4'd0; src_a = 32'hAAAA; src_b = 32'h1;
    tick();
    md_op = 4'd15;
    tick();
    md_op = 4'd11;
    tick();
    start = 1'b0;
    n_cmp++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL none_flags: got %b%b want 00", busy, done); end
    n_cmp++; if ({hi, lo} !== {32'h1234, 32'h55}) begin n_err++; $display("FAIL none_keep: got %h/%h want 1234/55", hi, lo); end
  endtask

  task automatic test_reset_mid();
    int nd;
    issue(4'd3, 32'd100, 32'd3);
    tick();
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({busy, hi, lo} !== 65'd0) begin n_err++; $display("FAIL rstmid: got busy %b hi %h lo %h want 0", busy, hi, lo); end
    tick();
    rst_n = 1'b1;
    nd = 0;
    repeat (14) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) nd++;
    end
    n_cmp++; if (nd != 0) begin n_err++; $display("FAIL rstmid_done: got %0d active cycles want 0", nd); end
    n_cmp++; if ({hi, lo} !== 64'd0) begin n_err++; $display("FAIL rstmid_nocommit: got %h%h want 0", hi, lo); end

    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    start = 1'b1; md_op = 4'd5; src_a = 32'h77;
    tick();
    start = 1'b0;
    n_cmp++; if (hi !== 32'h77) begin n_err++; $display("FAIL first_start: got %h want 77", hi); end
  endtask

  task automatic test_madd();
    int n;
    start = 1'b1; md_op = 4'd5; src_a = 32'd0;
    tick();
    md_op = 4'd6; src_a = 32'd10;
    tick();
    start = 1'b0;
`ifdef MD_UNIT_MADD_EN
    issue(4'd8, 32'd3, 32'd4);
    wait_done(n);
    n_cmp++; if (n != 5) begin n_err++; $display("FAIL maddu_cycles: got %0d want 5", n); end
    n_cmp++; if ({hi, lo} !== {32'd0, 32'd22}) begin n_err++; $display("FAIL maddu_res: got %h/%h want 0/16", hi, lo); end
    issue(4'd9, 32'hFFFFFFFE, 32'd3);
    wait_done(n);
    n_cmp++; if ({hi, lo} !== {32'd0, 32'd28}) begin n_err++; $display("FAIL msub_res: got %h/%h want 0/1c", hi, lo); end
    issue(4'd10, 32'd29, 32'd1);
    wait_done(n);
    n_cmp++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFF) begin n_err++; $display("FAIL msubu_wrap: got %h%h want all ones", hi, lo); end
`else
    start = 1'b1; md_op = 4'd8; src_a = 32'd3; src_b = 32'd4;
    tick();
    start = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL maddu_off_busy: got %b want 0", busy); end
    n = 0;
    repeat (8) begin
      tick();
      if (busy === 1'b1 || done === 1'b1) n++;
    end
    n_cmp++; if (n != 0) begin n_err++; $display("FAIL maddu_off_active: got %0d want 0", n); end
    n_cmp++; if ({hi, lo} !== {32'd0, 32'd10}) begin n_err++; $display("FAIL maddu_off_res: got %h/%h want 0/a", hi, lo); end
`endif
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_mult();
    test_div();
    test_busy_ignore();
    test_none();
    test_reset_mid();
    test_madd();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
